logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit on WIDTH-bit operands, with eight selectable Boolean ops.
- Adds a valid/ready handshake, an accumulate (fold) mode over multi-beat bursts, and a saturating beat counter.
- Sits between a operand source and a result consumer in the datapath.
- It is the sequential, generalised successor to the team's fixed 1-bit gate-level logic cells.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- CNT_W, 8, width of op_count (>=1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_op  in  3  op select: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (seed when first beat of accumulate burst)
- in_acc  in  1  beat belongs to accumulate burst
- in_last  in  1  last beat of burst (meaningful for in_acc=1; forwarded otherwise)
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_data  out  WIDTH  result
- out_last  out  1  copy of in_last of emitted beat
- op_count  out  CNT_W  saturating count of beats processed
- out_parity  out  1  only with LOGIC_UNIT_PARITY_EN

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, out_valid=0, out_data=0, out_last=0, op_count=0, acc_q=0, fsm=IDLE. Takes effect immediately. A burst in flight is discarded, with no partial output.
- Pipeline:
  - Stage 1 registers op, a, b, acc, last on accept.
  - Stage 2 computes and loads the output register.
- stall = out_valid && !out_ready. in_ready = !stall (combinational from out_ready; permitted). Both stages hold while stall=1.
- Latency: a beat accepted at edge N appears on out_valid at edge N+1 (output register loaded at N+1) when not stalled. Throughput is 1 beat/cycle.
- During stall: out_data, out_last and out_parity are stable. No beat is dropped or reordered.
- With no stall and no stage-1 beat, out_valid clears when out_ready consumes the current result.
- Op arithmetic is bitwise over WIDTH bits. NOT A and PASS A ignore B.
- FSM at stage 2: IDLE, ACCUM.
  - IDLE, acc beat: r = op(a,b), acc_q<=r.
    - If last: emit r, stay IDLE.
    - Else: no emit (beat absorbed), go ACCUM.
  - ACCUM, acc beat: r = op(a,acc_q), acc_q<=r.
    - If last: emit r, go IDLE.
    - Else: absorb, stay ACCUM.
  - Non-acc beat in either state: r = op(a,b), emitted; acc_q and state unchanged.
  - Op may differ per beat; each beat's own op is used.
- Back-to-back acc beats: stage 2 reads acc_q updated on the same edge the previous beat left. No bubble is required.
- An absorbed beat leaves out_valid=0 for that slot (or deasserts it after consumption).
- op_count increments once per beat leaving stage 1 (emitted or absorbed), and saturates at 2^CNT_W-1.
- Simultaneous accept and emit in the same cycle is supported.

Optional Feature:
- Macro: LOGIC_UNIT_PARITY_EN.
- Defined:
  - Port out_parity exists. It equals XOR-reduce of out_data, registered with out_data and stable under stall.
  - Reset value 0.
- Undefined: port and logic are absent. All other behaviour is identical.

Decomposition:
- Package logic_unit_pkg:
  - op encoding enum (OP_AND..OP_PASS, 3-bit)
  - FSM state enum (IDLE, ACCUM)
- Sub-module logic_op_core:
  - purely combinational WIDTH-bit op mux (op, a, b -> r)
  - instantiated once in stage 2; unit-testable in isolation

Test Plan:
- Reset: assert rst_n=0 mid-burst (fsm=ACCUM, out_valid=1) -> out_valid, out_data, op_count, acc_q all 0 immediately. Next acc beat is treated as IDLE seed.
- Ops, WIDTH=8, a=8'hA5, b=8'h3C, ops 0..7 back-to-back -> outputs 24, BD, DB, 42, 99, 66, 5A, A5 in order, one per cycle, first at accept+1 edge. op_count=8.
- Backpressure: hold out_ready=0 for 3 cycles with 2 beats pending -> in_ready=0, out_data stable. On release, both results arrive in order with no loss.
- Accumulate XOR burst: beats (a=01,b=00), (a=02), (a=04, last) with in_acc=1 -> single output 8'h07, out_last=1. op_count +3, fsm back to IDLE.
- Interleave: a non-acc beat PASS a=8'h55 inside an ACCUM burst -> emits 55 immediately, and the burst result is unaffected.
- Saturation/parity: CNT_W=4 with 20 beats -> op_count=15. With the macro, PASS a=8'h07 -> out_parity=1, and a=8'h99 -> 0.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined logic unit: op encoding and stage-2 FSM states.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/logic_unit_pipe_core.sv
// Combinational WIDTH-bit Boolean op mux (module logic_op_core); NOT A and PASS A ignore b.
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r
);

    always_comb begin
        r = '0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NOTA: r = ~a;
            OP_PASS: r = a;
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with valid/ready, accumulate bursts and a saturating beat count.
// Optional out_parity port enabled by defining LOGIC_UNIT_PARITY_EN.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] op_count
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    logic             stall;
    logic             adv;
    logic             s1_valid;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_acc;
    logic             s1_last;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] r;
    logic             emit;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign adv      = s1_valid && !stall;

    // Stage 1: capture the beat on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_AND;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_acc   <= 1'b0;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op   <= op_e'(in_op);
                s1_a    <= in_a;
                s1_b    <= in_b;
                s1_acc  <= in_acc;
                s1_last <= in_last;
            end
        end
    end

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .op (s1_op),
        .a  (s1_a),
        .b  (opnd_b),
        .r  (r)
    );

    // Continuing accumulate beats fold against acc_q instead of their own b
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        emit    = 1'b0;
        opnd_b  = s1_b;
        if (s1_acc && state_q == ACCUM)
            opnd_b = acc_q;
        if (s1_valid) begin
            if (s1_acc) begin
                acc_d = r;
                if (s1_last) begin
                    emit    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = ACCUM;
                end
            end else begin
                emit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
        end else if (adv) begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // Stage 2 output register; an absorbed beat leaves the slot empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1_valid && emit;
            if (s1_valid && emit) begin
                out_data <= r;
                out_last <= s1_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count <= '0;
        else if (adv && op_count != '1)
            op_count <= op_count + CNT_W'(1);
    end

`ifdef LOGIC_UNIT_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_parity <= 1'b0;
        else if (!stall && s1_valid && emit)
            out_parity <= ^r;
    end
`endif

endmodule
